// File: rtl/cond_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cond_pkg : condition codes and flag bit positions for cond_unit      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage
`default_nettype wire

// File: rtl/cond_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cond_check : combinational condition-code evaluator on {N,Z,C,V}     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  cond_t w_cond;
  logic  w_n, w_z, w_c, w_v;

  assign w_cond = cond_t'(Cond);
  assign w_n    = Flags[FLAG_N];
  assign w_z    = Flags[FLAG_Z];
  assign w_c    = Flags[FLAG_C];
  assign w_v    = Flags[FLAG_V];

  always_comb begin
    CondEx = 1'b0;
    case (w_cond)
      EQ: CondEx = w_z;
      NE: CondEx = ~w_z;
      CS: CondEx = w_c;
      CC: CondEx = ~w_c;
      MI: CondEx = w_n;
      PL: CondEx = ~w_n;
      VS: CondEx = w_v;
      VC: CondEx = ~w_v;
      HI: CondEx = w_c & ~w_z;
      LS: CondEx = ~w_c | w_z;
      GE: CondEx = (w_n == w_v);
      LT: CondEx = (w_n != w_v);
      GT: CondEx = ~w_z & (w_n == w_v);
      LE: CondEx = w_z | (w_n != w_v);
      AL: CondEx = 1'b1;
      NV: CondEx = 1'b0;
      default: CondEx = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cond_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cond_unit : flag register, condition gating and fail counter.        |
// | Optional sticky overflow flag enabled by macro COND_STICKY_OVF_EN.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cond_unit
  import cond_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    ALUFlags,
  input  logic [3:0]    Cond,
  input  logic [1:0]    FlagW,
  input  logic          PCS,
  input  logic          RegW,
  input  logic          MemW,
  input  logic          InstrValid,
  input  logic          CntClr,
  input  logic          StickyClr,
  output logic          PCSrc,
  output logic          RegWrite,
  output logic          MemWrite,
  output logic          CondEx,
  output logic [3:0]    Flags,
  output logic [CW-1:0] FailCnt,
  output logic          StickyV
);

  logic [3:0]    r_flags;
  logic [CW-1:0] r_fail_cnt;
  logic          w_cond_ex;
  logic          w_wr_nz;
  logic          w_wr_cv;
  logic          w_fail;

  cond_check u_cond_check (
    .Cond   (Cond),
    .Flags  (r_flags),
    .CondEx (w_cond_ex)
  );

  assign w_wr_nz = InstrValid & w_cond_ex & FlagW[1];
  assign w_wr_cv = InstrValid & w_cond_ex & FlagW[0];
  assign w_fail  = InstrValid & ~w_cond_ex;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else begin
      if (w_wr_nz) r_flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (w_wr_cv) r_flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  // Clear wins over increment; the counter sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fail_cnt <= '0;
    end else if (CntClr) begin
      r_fail_cnt <= '0;
    end else if (w_fail && (r_fail_cnt != {CW{1'b1}})) begin
      r_fail_cnt <= r_fail_cnt + 1'b1;
    end
  end

`ifdef COND_STICKY_OVF_EN
  logic r_sticky_v;
  logic w_sticky_set;

  assign w_sticky_set = w_wr_cv & ALUFlags[FLAG_V];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_v <= 1'b0;
    end else if (w_sticky_set) begin
      r_sticky_v <= 1'b1;
    end else if (StickyClr) begin
      r_sticky_v <= 1'b0;
    end
  end

  assign StickyV = r_sticky_v;
`else
  logic w_unused_sticky_clr;
  assign w_unused_sticky_clr = StickyClr;
  assign StickyV             = 1'b0;
`endif

  assign CondEx   = w_cond_ex;
  assign PCSrc    = PCS  & w_cond_ex;
  assign RegWrite = RegW & w_cond_ex;
  assign MemWrite = MemW & w_cond_ex;
  assign Flags    = r_flags;
  assign FailCnt  = r_fail_cnt;

endmodule
`default_nettype wire
